// File: rtl/sb_timer_pkg.sv
// Shared definitions for the sb_timer machine-timer slave: register indices,
// CTRL bit positions, write-response codes and a byte-lane merge helper.
package sb_timer_pkg;

   localparam logic [2:0] IDX_MTIME_LO = 3'd0;
   localparam logic [2:0] IDX_MTIME_HI = 3'd1;
   localparam logic [2:0] IDX_CMP_LO   = 3'd2;
   localparam logic [2:0] IDX_CMP_HI   = 3'd3;
   localparam logic [2:0] IDX_CTRL     = 3'd4;
   localparam logic [2:0] IDX_PRESC    = 3'd5;
   localparam logic [2:0] IDX_STATUS   = 3'd6;
   localparam logic [2:0] IDX_UNMAPPED = 3'd7;

   localparam int unsigned CTRL_EN_BIT = 0;
   localparam int unsigned CTRL_IE_BIT = 1;

   localparam logic BRESP_OK  = 1'b0;
   localparam logic BRESP_ERR = 1'b1;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sb_slave_if.sv
// AR/R and W/B handshake registers for one sb slave port. Presents single-cycle
// read/write strobes to the register block and captures its read data.
module sb_slave_if
   import sb_timer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,

   input  logic        sb_arvalid,
   output logic        sb_arready,
   input  logic [31:0] sb_araddr,
   output logic        sb_rvalid,
   input  logic        sb_rready,
   output logic [31:0] sb_rdata,

   input  logic        sb_wvalid,
   output logic        sb_wready,
   input  logic [31:0] sb_waddr,
   input  logic [31:0] sb_wdata,
   input  logic [3:0]  sb_wstrb,
   output logic        sb_bvalid,
   input  logic        sb_bready,
   output logic        sb_bresp,

   output logic        rd_en,
   output logic [2:0]  rd_idx,
   input  logic [31:0] rd_data,
   output logic        wr_en,
   output logic [2:0]  wr_idx,
   output logic [31:0] wr_data,
   output logic [3:0]  wr_strb
);

   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic        bvalid_q;
   logic        bresp_q;

   // Only the word index is decoded; the rest of the address is ignored.
   logic unused_addr;
   assign unused_addr = ^{sb_araddr[31:5], sb_araddr[1:0], sb_waddr[31:5], sb_waddr[1:0]};

   assign sb_arready = !rvalid_q;
   assign sb_wready  = !bvalid_q;
   assign sb_rvalid  = rvalid_q;
   assign sb_rdata   = rdata_q;
   assign sb_bvalid  = bvalid_q;
   assign sb_bresp   = bresp_q;

   assign rd_en   = sb_arvalid && !rvalid_q;
   assign rd_idx  = sb_araddr[4:2];
   assign wr_en   = sb_wvalid && !bvalid_q;
   assign wr_idx  = sb_waddr[4:2];
   assign wr_data = sb_wdata;
   assign wr_strb = sb_wstrb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else if (rd_en) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_data;
      end else if (sb_rready) begin
         rvalid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bvalid_q <= 1'b0;
         bresp_q  <= BRESP_OK;
      end else if (wr_en) begin
         bvalid_q <= 1'b1;
         bresp_q  <= (wr_idx == IDX_UNMAPPED) ? BRESP_ERR : BRESP_OK;
      end else if (sb_bready) begin
         bvalid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/sb_timer.sv
// Machine timer on an sb slave port: 64-bit mtime with prescaler, 64-bit
// mtimecmp, and a registered level interrupt when mtime >= mtimecmp.
module sb_timer
   import sb_timer_pkg::*;
#(
   parameter int unsigned PRESC_W = 16,
   parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        sb_clk,
   input  logic        sb_rst,

   input  logic        sb_arvalid,
   output logic        sb_arready,
   input  logic [31:0] sb_araddr,
   output logic        sb_rvalid,
   input  logic        sb_rready,
   output logic [31:0] sb_rdata,

   input  logic        sb_wvalid,
   output logic        sb_wready,
   input  logic [31:0] sb_waddr,
   input  logic [31:0] sb_wdata,
   input  logic [3:0]  sb_wstrb,
   output logic        sb_bvalid,
   input  logic        sb_bready,
   output logic        sb_bresp,

   output logic        timer_intr
);

   logic        rd_en;
   logic [2:0]  rd_idx;
   logic [31:0] rd_data;
   logic        wr_en;
   logic [2:0]  wr_idx;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;

   sb_slave_if u_slave_if (
      .clk        (sb_clk),
      .rst        (sb_rst),
      .sb_arvalid (sb_arvalid),
      .sb_arready (sb_arready),
      .sb_araddr  (sb_araddr),
      .sb_rvalid  (sb_rvalid),
      .sb_rready  (sb_rready),
      .sb_rdata   (sb_rdata),
      .sb_wvalid  (sb_wvalid),
      .sb_wready  (sb_wready),
      .sb_waddr   (sb_waddr),
      .sb_wdata   (sb_wdata),
      .sb_wstrb   (sb_wstrb),
      .sb_bvalid  (sb_bvalid),
      .sb_bready  (sb_bready),
      .sb_bresp   (sb_bresp),
      .rd_en      (rd_en),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .wr_strb    (wr_strb)
   );

   logic [63:0]        mtime_q, mtime_d;
   logic [63:0]        cmp_q, cmp_d;
   logic               en_q, en_d;
   logic               ie_q, ie_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] cnt_q, cnt_d;
   logic [31:0]        shadow_q;
   logic               intr_q;

   logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_presc;
   logic tick;
   logic mtime_ge;

   assign wr_mtime_lo = wr_en && (wr_idx == IDX_MTIME_LO);
   assign wr_mtime_hi = wr_en && (wr_idx == IDX_MTIME_HI);
   assign wr_cmp_lo   = wr_en && (wr_idx == IDX_CMP_LO);
   assign wr_cmp_hi   = wr_en && (wr_idx == IDX_CMP_HI);
   assign wr_ctrl     = wr_en && (wr_idx == IDX_CTRL);
   assign wr_presc    = wr_en && (wr_idx == IDX_PRESC);

   assign tick     = en_q && (cnt_q == presc_q);
   assign mtime_ge = (mtime_q >= cmp_q);

   always_comb begin
      cnt_d = cnt_q + PRESC_W'(1);
      if (wr_presc || !en_q || tick) cnt_d = '0;
   end

   // A bus write to either mtime half wins over the tick; the other half keeps
   // its pre-tick value so no carry leaks in.
   always_comb begin
      mtime_d = mtime_q + 64'(tick);
      if (wr_mtime_lo) begin
         mtime_d = {mtime_q[63:32], apply_wstrb(mtime_q[31:0], wr_data, wr_strb)};
      end else if (wr_mtime_hi) begin
         mtime_d = {apply_wstrb(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
      end
   end

   always_comb begin
      cmp_d   = cmp_q;
      en_d    = en_q;
      ie_d    = ie_q;
      presc_d = presc_q;
      if (wr_cmp_lo) cmp_d[31:0]  = apply_wstrb(cmp_q[31:0], wr_data, wr_strb);
      if (wr_cmp_hi) cmp_d[63:32] = apply_wstrb(cmp_q[63:32], wr_data, wr_strb);
      if (wr_ctrl && wr_strb[0]) begin
         en_d = wr_data[CTRL_EN_BIT];
         ie_d = wr_data[CTRL_IE_BIT];
      end
      if (wr_presc) presc_d = PRESC_W'(apply_wstrb(32'(presc_q), wr_data, wr_strb));
   end

   always_comb begin
      rd_data = '0;
      case (rd_idx)
         IDX_MTIME_LO: rd_data = mtime_q[31:0];
         IDX_MTIME_HI: rd_data = shadow_q;
         IDX_CMP_LO:   rd_data = cmp_q[31:0];
         IDX_CMP_HI:   rd_data = cmp_q[63:32];
         IDX_CTRL: begin
            rd_data[CTRL_EN_BIT] = en_q;
            rd_data[CTRL_IE_BIT] = ie_q;
         end
         IDX_PRESC:    rd_data = 32'(presc_q);
         IDX_STATUS:   rd_data = {31'b0, mtime_ge};
         default:      rd_data = '0;
      endcase
   end

   always_ff @(posedge sb_clk or posedge sb_rst) begin
      if (sb_rst) begin
         mtime_q <= '0;
         cmp_q   <= CMP_RST;
         en_q    <= 1'b0;
         ie_q    <= 1'b0;
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         mtime_q <= mtime_d;
         cmp_q   <= cmp_d;
         en_q    <= en_d;
         ie_q    <= ie_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Latching HI on a LO read makes a LO-then-HI pair coherent across a carry.
   always_ff @(posedge sb_clk or posedge sb_rst) begin
      if (sb_rst) begin
         shadow_q <= '0;
      end else if (rd_en && (rd_idx == IDX_MTIME_LO)) begin
         shadow_q <= mtime_q[63:32];
      end
   end

   always_ff @(posedge sb_clk or posedge sb_rst) begin
      if (sb_rst) intr_q <= 1'b0;
      else        intr_q <= ie_q && mtime_ge;
   end

   assign timer_intr = intr_q;

endmodule

// File: tb/tb_sb_timer.sv
// Self-checking bench for sb_timer: directed scenarios plus randomized register
// traffic checked against an arithmetic model of the register map.
module tb_sb_timer;
   import sb_timer_pkg::*;

   localparam int unsigned PW = 16;

   logic        sb_clk = 1'b0;
   logic        sb_rst = 1'b1;
   logic        sb_arvalid = 1'b0, sb_arready;
   logic [31:0] sb_araddr = '0;
   logic        sb_rvalid, sb_rready = 1'b0;
   logic [31:0] sb_rdata;
   logic        sb_wvalid = 1'b0, sb_wready;
   logic [31:0] sb_waddr = '0, sb_wdata = '0;
   logic [3:0]  sb_wstrb = '0;
   logic        sb_bvalid, sb_bready = 1'b0, sb_bresp;
   logic        timer_intr;

   sb_timer #(.PRESC_W(PW), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
      .sb_clk     (sb_clk),
      .sb_rst     (sb_rst),
      .sb_arvalid (sb_arvalid),
      .sb_arready (sb_arready),
      .sb_araddr  (sb_araddr),
      .sb_rvalid  (sb_rvalid),
      .sb_rready  (sb_rready),
      .sb_rdata   (sb_rdata),
      .sb_wvalid  (sb_wvalid),
      .sb_wready  (sb_wready),
      .sb_waddr   (sb_waddr),
      .sb_wdata   (sb_wdata),
      .sb_wstrb   (sb_wstrb),
      .sb_bvalid  (sb_bvalid),
      .sb_bready  (sb_bready),
      .sb_bresp   (sb_bresp),
      .timer_intr (timer_intr)
   );

   always #5 sb_clk = ~sb_clk;

   int unsigned cyc = 0;
   always @(posedge sb_clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [63:0] m_mtime, m_cmp;
   logic        m_en, m_ie;
   logic [31:0] m_presc, m_shadow;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] addr_of(input logic [2:0] idx);
      logic [31:0] a;
      a = $urandom;
      a[4:2] = idx;
      return a;
   endfunction

   task automatic model_reset();
      m_mtime = '0; m_cmp = '1; m_en = 0; m_ie = 0; m_presc = '0; m_shadow = '0;
   endtask

   task automatic bus_write(input logic [2:0] idx, input logic [31:0] data,
                            input logic [3:0] strb, output logic resp,
                            output logic b_next, output int unsigned hs);
      int guard = 0;
      @(negedge sb_clk);
      sb_wvalid = 1; sb_waddr = addr_of(idx); sb_wdata = data; sb_wstrb = strb;
      sb_bready = 1;
      while (!sb_wready && guard < 50) begin @(negedge sb_clk); guard++; end
      if (!sb_wready) begin
         n_tests++; n_fail++;
         $display("FAIL write_timeout: wready=%b want 1", sb_wready);
         sb_wvalid = 0; sb_bready = 0; resp = 1'bx; b_next = 0; hs = 0;
         return;
      end
      hs = cyc + 1;
      @(negedge sb_clk);
      sb_wvalid = 0;
      b_next = sb_bvalid; resp = sb_bresp;
      @(negedge sb_clk);
      sb_bready = 0;
   endtask

   task automatic bus_read(input logic [2:0] idx, output logic [31:0] data,
                           output int unsigned hs);
      int guard = 0;
      @(negedge sb_clk);
      sb_arvalid = 1; sb_araddr = addr_of(idx); sb_rready = 1;
      while (!sb_arready && guard < 50) begin @(negedge sb_clk); guard++; end
      hs = cyc + 1;
      @(negedge sb_clk);
      sb_arvalid = 0;
      guard = 0;
      while (!sb_rvalid && guard < 50) begin @(negedge sb_clk); guard++; end
      if (!sb_rvalid) begin
         n_tests++; n_fail++;
         $display("FAIL read_timeout: rvalid=%b want 1", sb_rvalid);
         data = 'x; sb_rready = 0;
         return;
      end
      data = sb_rdata;
      @(negedge sb_clk);
      sb_rready = 0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int unsigned hs;
      logic [2:0]  idxs [6] = '{IDX_CMP_LO, IDX_CMP_HI, IDX_CTRL, IDX_PRESC, IDX_MTIME_LO,
                                IDX_STATUS};
      logic [31:0] exps [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0};
      sb_rst = 1;
      model_reset();
      repeat (3) @(negedge sb_clk);
      sb_rst = 0;
      @(negedge sb_clk);
      n_tests++;
      if ({sb_arready, sb_wready, sb_rvalid, sb_bvalid, sb_bresp, timer_intr} !== 6'b110000)
      begin
         n_fail++;
         $display("FAIL rst_outputs: got ar,w,r,b,bresp,intr=%b want 110000",
                  {sb_arready, sb_wready, sb_rvalid, sb_bvalid, sb_bresp, timer_intr});
      end
      n_tests++;
      if (sb_rdata !== 32'h0) begin
         n_fail++; $display("FAIL rst_rdata: got %h want 0", sb_rdata);
      end
      for (int i = 0; i < 6; i++) begin
         bus_read(idxs[i], d, hs);
         n_tests++;
         if (d !== exps[i]) begin
            n_fail++; $display("FAIL rst_read idx%0d: got %h want %h", idxs[i], d, exps[i]);
         end
      end
   endtask

   task automatic test_prescaler();
      logic r, bn;
      logic [31:0] d;
      int unsigned hs, hs_en, hs_off;
      logic [63:0] exp;
      bus_write(IDX_PRESC, 32'd3, 4'hF, r, bn, hs);
      n_tests++;
      if ({r, bn} !== 2'b01) begin
         n_fail++; $display("FAIL presc_wr_resp: got bresp,bvalid=%b want 01", {r, bn});
      end
      m_presc = 3;
      bus_write(IDX_CTRL, 32'd1, 4'hF, r, bn, hs_en);
      n_tests++;
      if ({r, bn} !== 2'b01) begin
         n_fail++; $display("FAIL ctrl_wr_resp: got bresp,bvalid=%b want 01", {r, bn});
      end
      m_en = 1;
      repeat (20) @(negedge sb_clk);
      bus_read(IDX_MTIME_LO, d, hs);
      exp = 64'((hs - hs_en - 1) / (m_presc + 1));
      m_shadow = exp[63:32];
      n_tests++;
      if (d !== exp[31:0]) begin
         n_fail++; $display("FAIL presc_count: got %0d want %0d", d, exp[31:0]);
      end
      bus_write(IDX_CTRL, 32'd0, 4'hF, r, bn, hs_off);
      m_en = 0;
      m_mtime = 64'((hs_off - hs_en) / (m_presc + 1));
      for (int i = 0; i < 2; i++) begin
         repeat (3) @(negedge sb_clk);
         bus_read(IDX_MTIME_LO, d, hs);
         n_tests++;
         if (d !== m_mtime[31:0]) begin
            n_fail++; $display("FAIL presc_frozen%0d: got %0d want %0d", i, d, m_mtime[31:0]);
         end
      end
   endtask

   task automatic test_carry();
      logic r, bn;
      logic [31:0] d;
      int unsigned hs, hs0, hs_off;
      logic [63:0] base, v;
      base = 64'hFFFF_FFFE;
      bus_write(IDX_MTIME_LO, 32'hFFFF_FFFE, 4'hF, r, bn, hs);
      bus_write(IDX_MTIME_HI, 32'h0, 4'hF, r, bn, hs);
      bus_write(IDX_PRESC, 32'h0, 4'hF, r, bn, hs);
      m_presc = 0;
      bus_write(IDX_CTRL, 32'h1, 4'hF, r, bn, hs0);
      repeat (5) @(negedge sb_clk);
      bus_read(IDX_MTIME_HI, d, hs);
      n_tests++;
      if (d !== m_shadow) begin
         n_fail++; $display("FAIL carry_hi_stale: got %h want %h", d, m_shadow);
      end
      bus_read(IDX_MTIME_LO, d, hs);
      v = base + 64'(hs - hs0 - 1);
      m_shadow = v[63:32];
      n_tests++;
      if (d !== v[31:0]) begin
         n_fail++; $display("FAIL carry_lo: got %h want %h", d, v[31:0]);
      end
      bus_read(IDX_MTIME_HI, d, hs);
      n_tests++;
      if (d !== 32'h1 || d !== m_shadow) begin
         n_fail++; $display("FAIL carry_hi: got %h want %h", d, m_shadow);
      end
      bus_write(IDX_CTRL, 32'h0, 4'hF, r, bn, hs_off);
      m_en = 0;
      m_mtime = base + 64'(hs_off - hs0);
      bus_read(IDX_MTIME_LO, d, hs);
      m_shadow = m_mtime[63:32];
      n_tests++;
      if (d !== m_mtime[31:0]) begin
         n_fail++; $display("FAIL carry_frozen_lo: got %h want %h", d, m_mtime[31:0]);
      end
   endtask

   task automatic test_intr();
      logic r, bn;
      logic [31:0] d;
      int unsigned hs, hs0, hs_off;
      logic exp;
      bus_write(IDX_MTIME_LO, 32'h0, 4'hF, r, bn, hs);
      bus_write(IDX_MTIME_HI, 32'h0, 4'hF, r, bn, hs);
      bus_write(IDX_CMP_HI, 32'h0, 4'hF, r, bn, hs);
      bus_write(IDX_CMP_LO, 32'd10, 4'hF, r, bn, hs);
      m_cmp = 64'd10;
      bus_write(IDX_CTRL, 32'h3, 4'hF, r, bn, hs0);
      m_en = 1; m_ie = 1;
      // mtime equals k after edge k; the interrupt register sees it one edge later
      for (int i = 0; i < 16; i++) begin
         exp = ((cyc - hs0) >= 11);
         n_tests++;
         if (timer_intr !== exp) begin
            n_fail++;
            $display("FAIL intr_rise k=%0d: got %b want %b", cyc - hs0, timer_intr, exp);
         end
         @(negedge sb_clk);
      end
      bus_read(IDX_STATUS, d, hs);
      n_tests++;
      if (d !== 32'h1) begin
         n_fail++; $display("FAIL intr_status: got %h want 1", d);
      end
      bus_write(IDX_CMP_LO, 32'd1000, 4'hF, r, bn, hs);
      m_cmp = 64'd1000;
      n_tests++;
      if ({bn, timer_intr} !== 2'b10) begin
         n_fail++; $display("FAIL intr_drop: got bvalid,intr=%b want 10", {bn, timer_intr});
      end
      bus_write(IDX_CTRL, 32'h0, 4'hF, r, bn, hs_off);
      m_en = 0; m_ie = 0;
      m_mtime = 64'(hs_off - hs0);
      bus_read(IDX_STATUS, d, hs);
      n_tests++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL intr_status_low: got %h want 0", d);
      end
   endtask

   task automatic test_unmapped();
      logic r, bn;
      logic [31:0] d;
      int unsigned hs;
      bus_write(IDX_UNMAPPED, 32'h1234, 4'hF, r, bn, hs);
      n_tests++;
      if ({r, bn} !== 2'b11) begin
         n_fail++; $display("FAIL unmapped_bresp: got bresp,bvalid=%b want 11", {r, bn});
      end
      bus_write(IDX_STATUS, 32'hFFFF_FFFF, 4'hF, r, bn, hs);
      n_tests++;
      if ({r, bn} !== 2'b01) begin
         n_fail++; $display("FAIL status_wr_bresp: got bresp,bvalid=%b want 01", {r, bn});
      end
      bus_read(IDX_UNMAPPED, d, hs);
      n_tests++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL unmapped_read: got %h want 0", d);
      end
      bus_read(IDX_CMP_LO, d, hs);
      n_tests++;
      if (d !== m_cmp[31:0]) begin
         n_fail++; $display("FAIL unmapped_side_effect: got %h want %h", d, m_cmp[31:0]);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d;
      int unsigned hs;
      @(negedge sb_clk);
      sb_arvalid = 1; sb_araddr = addr_of(IDX_CMP_LO); sb_rready = 0;
      @(negedge sb_clk);
      sb_arvalid = 0;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if ({sb_rvalid, sb_arready} !== 2'b10 || sb_rdata !== m_cmp[31:0]) begin
            n_fail++;
            $display("FAIL stall%0d: got rvalid,arready=%b rdata=%h want 10 %h", i,
                     {sb_rvalid, sb_arready}, sb_rdata, m_cmp[31:0]);
         end
         @(negedge sb_clk);
      end
      sb_rready = 1;
      @(negedge sb_clk);
      sb_rready = 0;
      n_tests++;
      if ({sb_rvalid, sb_arready} !== 2'b01) begin
         n_fail++; $display("FAIL stall_release: got %b want 01", {sb_rvalid, sb_arready});
      end
      // Simultaneous read and write of CTRL: read must see the old value
      sb_arvalid = 1; sb_araddr = addr_of(IDX_CTRL); sb_rready = 1;
      sb_wvalid = 1; sb_waddr = addr_of(IDX_CTRL); sb_wdata = 32'h2; sb_wstrb = 4'hF;
      sb_bready = 1;
      @(negedge sb_clk);
      sb_arvalid = 0; sb_wvalid = 0;
      n_tests++;
      if ({sb_rvalid, sb_bvalid, sb_bresp} !== 3'b110 || sb_rdata !== {30'b0, m_ie, m_en})
      begin
         n_fail++;
         $display("FAIL simul_rw: got r,b,bresp=%b rdata=%h want 110 %h",
                  {sb_rvalid, sb_bvalid, sb_bresp}, sb_rdata, {30'b0, m_ie, m_en});
      end
      @(negedge sb_clk);
      sb_rready = 0; sb_bready = 0;
      m_ie = 1;
      bus_read(IDX_CTRL, d, hs);
      n_tests++;
      if (d !== 32'h2) begin
         n_fail++; $display("FAIL simul_rw_after: got %h want 2", d);
      end
      // Reset with both responses pending
      @(negedge sb_clk);
      sb_arvalid = 1; sb_araddr = addr_of(IDX_CMP_LO);
      sb_wvalid = 1; sb_waddr = addr_of(IDX_CMP_HI); sb_wdata = 32'h5; sb_wstrb = 4'hF;
      @(negedge sb_clk);
      sb_arvalid = 0; sb_wvalid = 0;
      n_tests++;
      if ({sb_rvalid, sb_bvalid} !== 2'b11) begin
         n_fail++; $display("FAIL pre_rst_pending: got %b want 11", {sb_rvalid, sb_bvalid});
      end
      #2 sb_rst = 1;
      #1;
      n_tests++;
      if ({sb_rvalid, sb_bvalid, sb_arready, sb_wready} !== 4'b0011) begin
         n_fail++;
         $display("FAIL async_rst: got r,b,ar,w=%b want 0011",
                  {sb_rvalid, sb_bvalid, sb_arready, sb_wready});
      end
      @(negedge sb_clk);
      sb_rst = 0;
      model_reset();
      bus_read(IDX_CMP_HI, d, hs);
      n_tests++;
      if (d !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL rst_cmp_hi: got %h want ffffffff", d);
      end
      bus_read(IDX_CTRL, d, hs);
      n_tests++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL rst_ctrl: got %h want 0", d);
      end
   endtask

   // Random register traffic with the counter disabled, so mtime only changes by writes.
   task automatic test_random();
      logic r, bn;
      logic [31:0] d, data, exp;
      logic [3:0]  strb;
      logic [2:0]  idx;
      int unsigned hs;
      for (int n = 0; n < 80; n++) begin
         idx = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if (idx == IDX_CTRL) data[0] = 1'b0;
            bus_write(idx, data, strb, r, bn, hs);
            case (idx)
               3'd0: m_mtime[31:0]  = merge(m_mtime[31:0], data, strb);
               3'd1: m_mtime[63:32] = merge(m_mtime[63:32], data, strb);
               3'd2: m_cmp[31:0]    = merge(m_cmp[31:0], data, strb);
               3'd3: m_cmp[63:32]   = merge(m_cmp[63:32], data, strb);
               3'd4: if (strb[0]) m_ie = data[1];
               3'd5: m_presc = merge(m_presc, data, strb) & 32'h0000_FFFF;
               default: ;
            endcase
            n_tests++;
            if ({r, bn} !== {(idx == 3'd7), 1'b1}) begin
               n_fail++;
               $display("FAIL rnd_wr%0d idx%0d: got bresp,bvalid=%b want %b", n, idx,
                        {r, bn}, {(idx == 3'd7), 1'b1});
            end
         end else begin
            bus_read(idx, d, hs);
            case (idx)
               3'd0: begin exp = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
               3'd1: exp = m_shadow;
               3'd2: exp = m_cmp[31:0];
               3'd3: exp = m_cmp[63:32];
               3'd4: exp = {30'b0, m_ie, m_en};
               3'd5: exp = m_presc;
               3'd6: exp = {31'b0, (m_mtime >= m_cmp)};
               default: exp = 32'h0;
            endcase
            n_tests++;
            if (d !== exp) begin
               n_fail++; $display("FAIL rnd_rd%0d idx%0d: got %h want %h", n, idx, d, exp);
            end
         end
         n_tests++;
         if (timer_intr !== (m_ie && (m_mtime >= m_cmp))) begin
            n_fail++;
            $display("FAIL rnd_intr%0d: got %b want %b", n, timer_intr,
                     (m_ie && (m_mtime >= m_cmp)));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_prescaler();
      test_carry();
      test_intr();
      test_unmapped();
      test_backpressure();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
